// File: rtl/alu_channel_array.sv
// Multi-lane ALU behind a 2-stage valid/ready pipeline, with a per-lane accumulator,
// carry/borrow and zero flags, and a wrapping count of delivered result bundles.
module alu_channel_array #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNTW     = 16
) (
  input  logic                           clock,
  input  logic                           resetb,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*WIDTH-1:0]      a,
  input  logic [CHANNELS*WIDTH-1:0]      b,
  input  logic [CHANNELS*3-1:0]          sel,
  input  logic                           acc_clr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*(WIDTH+1)-1:0]  result,
  output logic [CHANNELS-1:0]            zero,
  output logic [CNTW-1:0]                txn_count
);

  localparam int unsigned RW = WIDTH + 1;

  localparam logic [2:0] OpAdd     = 3'b000;
  localparam logic [2:0] OpSub     = 3'b001;
  localparam logic [2:0] OpAnd     = 3'b010;
  localparam logic [2:0] OpOr      = 3'b011;
  localparam logic [2:0] OpXor     = 3'b100;
  localparam logic [2:0] OpAccAdd  = 3'b101;
  localparam logic [2:0] OpAccLoad = 3'b110;
  localparam logic [2:0] OpAccRead = 3'b111;

  logic                          r_v1;
  logic                          r_v2;
  logic [CHANNELS*WIDTH-1:0]     r_a;
  logic [CHANNELS*WIDTH-1:0]     r_b;
  logic [CHANNELS*3-1:0]         r_sel;
  logic [CHANNELS*RW-1:0]        r_result;
  logic [CHANNELS-1:0]           r_zero;
  logic [CNTW-1:0]               r_txn;

  logic                          w_adv2;
  logic                          w_accept;
  logic                          w_xfer;
  logic [CHANNELS*RW-1:0]        w_result;
  logic [CHANNELS-1:0]           w_zero;

  assign w_adv2   = ~r_v2 | out_ready;
  assign in_ready = ~r_v1 | w_adv2;
  assign w_accept = in_valid & in_ready;
  assign w_xfer   = w_adv2 & r_v1;

  assign out_valid = r_v2;
  assign result    = r_result;
  assign zero      = r_zero;
  assign txn_count = r_txn;

  // Stage 1: operand capture.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_v1  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= '0;
    end else if (w_accept) begin
      r_v1  <= 1'b1;
      r_a   <= a;
      r_b   <= b;
      r_sel <= sel;
    end else if (w_adv2) begin
      r_v1  <= 1'b0;
    end
  end

  // Stage 2: computed results, held while the consumer stalls.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_v2     <= 1'b0;
      r_result <= '0;
      r_zero   <= '1;
    end else if (w_xfer) begin
      r_v2     <= 1'b1;
      r_result <= w_result;
      r_zero   <= w_zero;
    end else if (out_ready) begin
      r_v2     <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_txn <= '0;
    end else if (r_v2 && out_ready) begin
      r_txn <= r_txn + CNTW'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [RW-1:0]    w_r;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] r_acc;

    assign w_a  = r_a[g*WIDTH +: WIDTH];
    assign w_b  = r_b[g*WIDTH +: WIDTH];
    assign w_op = r_sel[g*3 +: 3];

    always_comb begin
      w_r       = '0;
      w_acc_nxt = r_acc;
      unique case (w_op)
        OpAdd:     w_r = {1'b0, w_a} + {1'b0, w_b};
        OpSub:     w_r = {1'b0, w_a} - {1'b0, w_b};
        OpAnd:     w_r = {1'b0, w_a & w_b};
        OpOr:      w_r = {1'b0, w_a | w_b};
        OpXor:     w_r = {1'b0, w_a ^ w_b};
        OpAccAdd: begin
          w_r       = {1'b0, r_acc} + {1'b0, w_a};
          w_acc_nxt = w_r[WIDTH-1:0];
        end
        OpAccLoad: begin
          w_r       = {1'b0, w_a};
          w_acc_nxt = w_a;
        end
        OpAccRead: w_r = {1'b0, r_acc};
        default:   w_r = '0;
      endcase
    end

    assign w_result[g*RW +: RW] = w_r;
    assign w_zero[g]            = ~|w_r[WIDTH-1:0];

    // Clear beats a coincident update; the outgoing result still used the old value.
    always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
        r_acc <= '0;
      end else if (acc_clr) begin
        r_acc <= '0;
      end else if (w_xfer) begin
        r_acc <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_channel_array.sv
// Bench for alu_channel_array: directed literal cases plus randomized traffic compared
// each cycle against an in-order bundle queue model.
module tb_alu_channel_array;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int CNTW = 4;
  localparam int RW = W + 1;

  logic                clock;
  logic                resetb;
  logic                in_valid;
  logic                in_ready;
  logic [CH*W-1:0]     a;
  logic [CH*W-1:0]     b;
  logic [CH*3-1:0]     sel;
  logic                acc_clr;
  logic                out_valid;
  logic                out_ready;
  logic [CH*RW-1:0]    result;
  logic [CH-1:0]       zero;
  logic [CNTW-1:0]     txn_count;

  alu_channel_array #(.WIDTH(W), .CHANNELS(CH), .CNTW(CNTW)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .txn_count (txn_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bundles in arrival order; a bundle is computed when it reaches the output slot.
  typedef struct {
    logic [CH*W-1:0]  a;
    logic [CH*W-1:0]  b;
    logic [CH*3-1:0]  sel;
    bit               done;
    logic [CH*RW-1:0] res;
    logic [CH-1:0]    zero;
  } ent_t;

  ent_t q[$];
  int   macc[CH];
  int   mcnt;

  always @(posedge clock or negedge resetb) begin : model
    ent_t e;
    bit   acc_ok;
    int   av, bv, op, r;
    if (!resetb) begin
      q.delete();
      for (int l = 0; l < CH; l++) macc[l] = 0;
      mcnt = 0;
    end else begin
      acc_ok = in_valid && (q.size() < 2 || out_ready);
      if (q.size() > 0 && q[0].done && out_ready) begin
        void'(q.pop_front());
        mcnt = (mcnt + 1) % (1 << CNTW);
      end
      if (q.size() > 0 && !q[0].done) begin
        e = q[0];
        for (int l = 0; l < CH; l++) begin
          av = int'(e.a[l*W +: W]);
          bv = int'(e.b[l*W +: W]);
          op = int'(e.sel[l*3 +: 3]);
          case (op)
            0: r = av + bv;
            1: r = av - bv + (1 << RW);
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: begin r = macc[l] + av; macc[l] = r % (1 << W); end
            6: begin r = av; macc[l] = av; end
            default: r = macc[l];
          endcase
          r = r % (1 << RW);
          e.res[l*RW +: RW] = r[RW-1:0];
          e.zero[l] = (r % (1 << W)) == 0;
        end
        e.done = 1'b1;
        q[0] = e;
      end
      if (acc_clr) for (int l = 0; l < CH; l++) macc[l] = 0;
      if (acc_ok) begin
        e.a = a; e.b = b; e.sel = sel; e.done = 1'b0; e.res = '0; e.zero = '0;
        q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin : compare
    bit exp_v;
    if (resetb) begin
      exp_v = q.size() > 0 && q[0].done;
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2 || out_ready));
      chk("txn_count", 32'(txn_count), 32'(mcnt));
      if (exp_v && out_valid) begin
        chk("result", 32'(result), 32'(q[0].res));
        chk("zero", 32'(zero), 32'(q[0].zero));
      end
    end
  end

  logic [CH+CH*RW-1:0] got[$];
  always @(posedge clock) begin
    if (resetb && out_valid && out_ready) got.push_back({zero, result});
  end

  task automatic send(input logic [CH*W-1:0] av, input logic [CH*W-1:0] bv,
                      input logic [CH*3-1:0] sv, input logic clr);
    int n = 0;
    bit ok = 0;
    a = av; b = bv; sel = sv; acc_clr = clr; in_valid = 1'b1;
    while (!ok && n < 50) begin
      #2;
      ok = in_ready;
      @(posedge clock);
      #1;
      acc_clr = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_got(input int n);
    int c = 0;
    while (got.size() < n && c < 50) begin
      @(posedge clock);
      #1;
      c++;
    end
    chk("got_count", 32'(got.size()), 32'(n));
  endtask

  task automatic pulse_reset();
    resetb = 1'b0;
    @(posedge clock);
    #1;
    resetb = 1'b1;
  endtask

  bit rnd_done;

  initial begin
    in_valid = 0; a = '0; b = '0; sel = '0; acc_clr = 0; out_ready = 1;
    resetb = 1;
    #1 resetb = 0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'h3);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 resetb = 1;

    // Arithmetic and two-cycle latency.
    send({4'd3, 4'd9}, {4'd5, 4'd9}, {3'b001, 3'b000}, 1'b0);
    #2;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clock);
    #2;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("arith_result", 32'(result), 32'({5'b11110, 5'b10010}));
    chk("arith_zero", 32'(zero), 32'd0);
    repeat (2) @(posedge clock);
    #1;

    // Logic ops.
    got.delete();
    send({4'b1100, 4'b1100}, {4'b1010, 4'b1010}, {3'b011, 3'b010}, 1'b0);
    send({4'd5, 4'b1100}, {4'd5, 4'b1010}, {3'b100, 3'b100}, 1'b0);
    wait_got(2);
    chk("and_or", 32'(got[0]), 32'({2'b00, 5'b01110, 5'b01000}));
    chk("xor_zero", 32'(got[1]), 32'({2'b10, 5'b00000, 5'b00110}));

    // Accumulator chain, then clear coincident with an ACC_ADD transfer.
    got.delete();
    send({4'd0, 4'd7}, '0, {3'b111, 3'b110}, 1'b0);
    send({4'd0, 4'd6}, '0, {3'b111, 3'b101}, 1'b0);
    send({4'd0, 4'd3}, '0, {3'b111, 3'b101}, 1'b0);
    send({4'd0, 4'd0}, '0, {3'b111, 3'b111}, 1'b0);
    send({4'd0, 4'd5}, '0, {3'b111, 3'b110}, 1'b0);
    send({4'd0, 4'd2}, '0, {3'b111, 3'b101}, 1'b0);
    send({4'd0, 4'd0}, '0, {3'b111, 3'b111}, 1'b1);
    wait_got(7);
    chk("acc_load7", 32'(got[0]), 32'({2'b10, 5'd0, 5'b00111}));
    chk("acc_add6", 32'(got[1]), 32'({2'b10, 5'd0, 5'b01101}));
    chk("acc_add3", 32'(got[2]), 32'({2'b11, 5'd0, 5'b10000}));
    chk("acc_read0", 32'(got[3]), 32'({2'b11, 5'd0, 5'b00000}));
    chk("clr_preval", 32'(got[5]), 32'({2'b10, 5'd0, 5'b00111}));
    chk("clr_read", 32'(got[6]), 32'({2'b11, 5'd0, 5'b00000}));

    // Reset with both stages full.
    out_ready = 0;
    send({4'd0, 4'd1}, '0, '0, 1'b0);
    send({4'd0, 4'd2}, '0, '0, 1'b0);
    #2;
    resetb = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'h3);
    chk("mid_rst_txn", 32'(txn_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 resetb = 1;

    // Backpressure: two accepted, third waits.
    got.delete();
    send({4'd0, 4'd1}, '0, '0, 1'b0);
    send({4'd0, 4'd2}, '0, '0, 1'b0);
    #2;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    fork
      begin
        send({4'd0, 4'd3}, '0, '0, 1'b0);
        send({4'd0, 4'd4}, '0, '0, 1'b0);
      end
      begin
        @(posedge clock);
        #1 out_ready = 1;
      end
    join
    wait_got(4);
    repeat (3) @(posedge clock);
    #1;
    chk("bp_no_dup", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", 32'(got[i]), 32'({2'b10, 5'd0, 5'(i + 1)}));
    chk("bp_txn4", 32'(txn_count), 32'd4);

    // Counter wrap at CNTW=4.
    pulse_reset();
    for (int i = 0; i < 17; i++) send(8'(i), 8'(i + 1), '0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("txn_wrap", 32'(txn_count), 32'd1);

    // Randomized traffic with random backpressure and clears.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(3) != 0) begin
            send(8'($urandom), 8'($urandom), 6'($urandom), $urandom_range(7) == 0);
          end else begin
            acc_clr = $urandom_range(7) == 0;
            @(posedge clock);
            #1 acc_clr = 0;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = $urandom_range(2) != 0;
          @(posedge clock);
          #1;
        end
      end
    join
    out_ready = 1;
    repeat (5) @(posedge clock);
    #1;
    chk("drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_channel_array.md
# alu_channel_array

Parametrised multi-channel ALU for the user project area: CHANNELS independent WIDTH-bit ALU lanes share one valid/ready input and output handshake, with a 2-stage register pipeline, a per-lane accumulator, carry/borrow and zero flags, and a wrapping transaction counter. It is the successor to the fixed two-lane 4-bit, 2-bit-select ALU pair driven from `mprj_io`. It sits between the IO-pad operand/select capture logic and the result drivers.

## Interface
- WIDTH, 4, operand width per lane (2..16)
- CHANNELS, 2, number of lanes (1..8)
- CNTW, 16, transaction counter width
- clock  in  1  single clock, rising edge
- resetb  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- a  in  CHANNELS*WIDTH  operand A, lane i at [i*WIDTH +: WIDTH]
- b  in  CHANNELS*WIDTH  operand B, same packing
- sel  in  CHANNELS*3  per-lane opcode, lane i at [i*3 +: 3]
- acc_clr  in  1  synchronous clear of all accumulators
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream accepts result
- result  out  CHANNELS*(WIDTH+1)  lane i at [i*(WIDTH+1) +: WIDTH+1]; bit WIDTH = carry/borrow
- zero  out  CHANNELS  lane i: result low WIDTH bits == 0
- txn_count  out  CNTW  number of result bundles accepted downstream

## Operation
- Opcodes per lane: 000 ADD {c,r}=A+B; 001 SUB {bw,r}=({0,A}-{0,B}) mod 2^(WIDTH+1), MSB=1 iff A<B; 010 AND; 011 OR; 100 XOR; 101 ACC_ADD acc<=acc+A, result={carry,new acc}; 110 ACC_LOAD acc<=A, result={0,A}; 111 ACC_READ result={0,acc}, acc unchanged.
- Logic ops, ACC_LOAD, ACC_READ: result bit WIDTH = 0.
- Accumulators: WIDTH bits per lane, wrap modulo 2^WIDTH.
- Pipeline: stage 1 (S1) registers a, b, sel with valid v1; stage 2 (S2) registers computed result/zero with valid v2. Computation, including accumulator read-modify-write, happens on the S1->S2 transfer.
- adv2 = !v2 | out_ready; in_ready = !v1 | adv2 (combinational, no dependency on in_valid).
- S1 loads when in_valid & in_ready; v1 clears when S1 transfers and no new bundle is accepted.
- S2 loads from S1 when adv2 & v1; v2 clears when out_ready & !v1.
- Accumulators update only on an S1->S2 transfer of an ACC_ADD/ACC_LOAD lane.
- acc_clr: zeroes all accumulators at the next edge; if coincident with an accumulator-updating transfer, clear wins for acc; the transferred result still carries the value computed from the pre-clear acc.
- txn_count increments on out_valid & out_ready, wraps from 2^CNTW-1 to 0.
- result, zero, out_valid held stable while out_valid & !out_ready.

## Timing
- Reset (resetb low, asynchronous): v1=v2=0, out_valid=0, result=0, zero=all 1, all acc=0, txn_count=0; in_ready=1 immediately after reset.
- Deassertion of resetb sampled synchronously; first accept possible at first rising edge with resetb high.
- Latency: bundle accepted at edge k -> out_valid high after edge k+1, i.e. 2 cycles from in_valid to result.
- Throughput: 1 bundle/cycle with out_ready held high.
- Back-to-back ACC ops on a lane see the previous op's accumulator value (no hazard, no bubble).
- Stall: with out_ready low, at most 2 bundles held (S1, S2); in_ready drops after the second accept.
- Reset mid-operation: in-flight bundles discarded, no partial output, counter cleared.

## Test plan
- Reset: resetb low mid-stream with v1=v2=1 -> out_valid=0, result=0, zero=2'b11, txn_count=0, in_ready=1 immediately.
- Arithmetic (WIDTH=4, CHANNELS=2): lane0 A=9,B=9 ADD, lane1 A=3,B=5 SUB -> lane0 result 5'b10010 zero=0; lane1 result 5'b11110 (borrow=1); out_valid 2 cycles after accept.
- Logic: A=4'b1100,B=4'b1010 with AND/OR/XOR -> 5'b01000 / 5'b01110 / 5'b00110; A=B XOR -> zero=1.
- Accumulator: back-to-back ACC_LOAD 7, ACC_ADD 6, ACC_ADD 3, ACC_READ -> results 5'b00111, 5'b01101, 5'b10000 (carry, zero=1), 5'b00000; acc_clr on the ACC_ADD 3 transfer -> that result 5'b10000, next ACC_READ 0.
- Backpressure: 4 bundles streamed with out_ready low 3 cycles -> in_ready low after 2 accepts, no bundle lost or duplicated, order preserved; txn_count=4 at end.
- Counter wrap (CNTW=4): 17 accepted results -> txn_count=1.
